// File: rtl/time_down.sv
// Down-counting timer: loads a period, counts to zero, pulses timeout, then reloads or stops.
// All outputs registered; control priority is rst > ~en > stop > start > pause/zero/decrement.
module time_down #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic [WIDTH-1:0] cfg_load,
   input  logic             cfg_repeat,
   input  logic             irq_clr,
   output logic [WIDTH-1:0] cnt,
   output logic             timeout,
   output logic             irq,
   output logic             busy,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           cur, nxt;
   logic [WIDTH-1:0] cnt_nxt;
   logic             timeout_nxt;
   logic             irq_nxt;
   logic             busy_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cur     <= IDLE;
         cnt     <= '0;
         timeout <= 1'b0;
         irq     <= 1'b0;
         busy    <= 1'b0;
      end else begin
         cur     <= nxt;
         cnt     <= cnt_nxt;
         timeout <= timeout_nxt;
         irq     <= irq_nxt;
         busy    <= busy_nxt;
      end
   end

   always_comb begin
      nxt         = cur;
      cnt_nxt     = cnt;
      timeout_nxt = 1'b0;
      // a zero event on the same edge as irq_clr overrides the clear below
      irq_nxt     = irq & ~irq_clr;

      if (!en || stop) begin
         nxt     = IDLE;
         cnt_nxt = '0;
      end else if (start && (cfg_load != '0)) begin
         nxt     = RUN;
         cnt_nxt = cfg_load;
      end else begin
         case (cur)
            RUN: begin
               if (pause) begin
                  nxt = PAUSE;
               end else if (cnt != '0) begin
                  cnt_nxt = cnt - 1'b1;
               end else begin
                  timeout_nxt = 1'b1;
                  irq_nxt     = 1'b1;
                  if (cfg_repeat && (cfg_load != '0)) begin
                     cnt_nxt = cfg_load;
                  end else begin
                     nxt     = DONE;
                     cnt_nxt = '0;
                  end
               end
            end
            // resume edge only leaves PAUSE; decrement resumes on the following edge
            PAUSE: begin
               if (!pause) nxt = RUN;
            end
            DONE: begin
               cnt_nxt = '0;
            end
            default: begin
            end
         endcase
      end

      busy_nxt = (nxt == RUN) || (nxt == PAUSE);
   end

   assign state = cur;

endmodule

// File: tb/tb_time_down.sv
// Directed bench for time_down: hand-computed count sequences, pause timing and control priority.
module tb_time_down;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst, en, start, stop, pause, cfg_repeat, irq_clr;
   logic [WIDTH-1:0] cfg_load;
   logic [WIDTH-1:0] cnt;
   logic             timeout, irq, busy;
   logic [1:0]       state;

   int checks = 0;
   int errors = 0;

   time_down #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .start      (start),
      .stop       (stop),
      .pause      (pause),
      .cfg_load   (cfg_load),
      .cfg_repeat (cfg_repeat),
      .irq_clr    (irq_clr),
      .cnt        (cnt),
      .timeout    (timeout),
      .irq        (irq),
      .busy       (busy),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // advance until timeout is seen; n counts edges since the start edge, capped to avoid hanging
   task automatic wait_timeout(input int n0, output int n);
      n = n0;
      while (!timeout && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic do_start(input logic [WIDTH-1:0] l);
      cfg_load = l;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   int rep_seq[8] = '{2, 1, 0, 3, 2, 1, 0, 3};
   int n;

   initial begin
      rst = 1'b1; en = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
      cfg_repeat = 1'b1; irq_clr = 1'b0; cfg_load = '0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_cnt", cnt, 0);
      check("rst_state", state, 0);
      check("rst_busy", busy, 0);

      // repeat mode, L=3
      cfg_repeat = 1'b1;
      do_start(3);
      check("rep_first", cnt, 3);
      check("rep_first_to", timeout, 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("rep_cnt%0d", i), cnt, rep_seq[i]);
         check($sformatf("rep_to%0d", i), timeout, (rep_seq[i] == 3) ? 1 : 0);
      end
      check("rep_irq", irq, 1);
      check("rep_busy", busy, 1);

      // reset mid-run
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("mrst_cnt", cnt, 0);
      check("mrst_state", state, 0);
      check("mrst_to", timeout, 0);
      check("mrst_irq", irq, 0);
      check("mrst_busy", busy, 0);

      // one-shot, L=2, run twice
      cfg_repeat = 1'b0;
      for (int r = 0; r < 2; r++) begin
         do_start(2);
         check("os_cnt2", cnt, 2);
         check("os_state_run", state, 1);
         tick();
         check("os_cnt1", cnt, 1);
         tick();
         check("os_cnt0", cnt, 0);
         check("os_to_early", timeout, 0);
         tick();
         check("os_state_done", state, 3);
         check("os_cnt_done", cnt, 0);
         check("os_to", timeout, 1);
         check("os_busy", busy, 0);
         tick();
         check("os_to_single", timeout, 0);
         check("os_stay_done", state, 3);
      end

      // pause one edge at cnt=5, L=10: zero event moves from edge 11 to edge 13
      do_start(10);
      for (int i = 0; i < 5; i++) tick();
      check("pz_cnt5", cnt, 5);
      pause = 1'b1;
      tick();
      pause = 1'b0;
      check("pz_state", state, 2);
      check("pz_hold", cnt, 5);
      check("pz_busy", busy, 1);
      tick();
      check("pz_resume_state", state, 1);
      check("pz_resume_cnt", cnt, 5);
      wait_timeout(7, n);
      check("pz_zero_edge", n, 13);

      // ~en beats start
      cfg_repeat = 1'b1;
      do_start(5);
      tick();
      en = 1'b0;
      start = 1'b1;
      tick();
      en = 1'b1;
      start = 1'b0;
      check("en_state", state, 0);
      check("en_cnt", cnt, 0);

      // irq_clr on a zero-event edge loses to the set
      do_start(1);
      tick();
      check("clr_cnt0", cnt, 0);
      irq_clr = 1'b1;
      tick();
      check("clr_to", timeout, 1);
      check("clr_irq_kept", irq, 1);
      tick();
      irq_clr = 1'b0;
      check("clr_irq_cleared", irq, 0);

      // stop beats start
      stop = 1'b1;
      start = 1'b1;
      cfg_load = 4;
      tick();
      stop = 1'b0;
      start = 1'b0;
      check("stop_state", state, 0);
      check("stop_cnt", cnt, 0);

      // start with zero load in IDLE is ignored
      do_start(0);
      check("z_state", state, 0);
      check("z_cnt", cnt, 0);
      check("z_busy", busy, 0);

      // cfg_load 7 -> 2 mid-run: period 8, then period 3
      do_start(7);
      tick();
      tick();
      cfg_load = 2;
      wait_timeout(2, n);
      check("chg_period1", n, 8);
      check("chg_reload", cnt, 2);
      tick();
      wait_timeout(1, n);
      check("chg_period2", n, 3);

      // maximum load value
      do_start('1);
      check("max_load", cnt, 64'hFFFF_FFFF);
      tick();
      check("max_dec", cnt, 64'hFFFF_FFFE);
      stop = 1'b1;
      tick();
      stop = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
